mini_core_c2f_arb: RTL and testbench

Two-requester arbiter sharing a mini_core_tile's single local injection port into the fabric. It arbitrates between the core's outgoing request stream (C2F request FIFO head) and the read-response stream (rd_rsp FIFO head). Responses get priority to guarantee fabric drain, and a bounded-burst rule prevents request starvation. The winner goes through one registered output stage toward the fabric local input, with ready backpressure and a stall watchdog.

---
 rtl/common_pkg.sv | 10 +
 rtl/mini_core_pkg.sv | 9 +
 rtl/mini_core_c2f_arb.sv | 105 ++++++++++
 tb/tb_mini_core_c2f_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Types shared across the mini_core tile and fabric.
package common_pkg;

   typedef struct packed {
      logic [3:0]  dst;
      logic [3:0]  op;
      logic [31:0] data;
   } t_tile_trans;

endpackage

// File: rtl/mini_core_pkg.sv
// mini_core-local types and default constants (C2F injection arbiter).
package mini_core_pkg;

   typedef enum logic {ARB_SRC_REQ, ARB_SRC_RSP} t_c2f_arb_src;

   localparam int          C2F_ARB_RSP_BURST_MAX = 4;
   localparam logic [15:0] C2F_ARB_STALL_LIMIT   = 16'd1000;

endpackage

// File: rtl/mini_core_c2f_arb.sv
// Arbitrates request and read-response FIFO heads onto the tile's single fabric
// injection port: response priority with a bounded burst, one registered output stage.
module mini_core_c2f_arb
   import common_pkg::*;
   import mini_core_pkg::*;
#(
   parameter int          RSP_BURST_MAX = C2F_ARB_RSP_BURST_MAX,
   parameter logic [15:0] STALL_LIMIT   = C2F_ARB_STALL_LIMIT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   input  t_tile_trans  req_trans,
   output logic         req_ready,
   input  logic         rsp_valid,
   input  t_tile_trans  rsp_trans,
   output logic         rsp_ready,
   input  logic         fab_ready,
   output logic         out_valid,
   output t_tile_trans  out_trans,
   output t_c2f_arb_src out_src,
   output logic         stall_err
);

   localparam int BW = $clog2(RSP_BURST_MAX + 1);

   logic         out_valid_q, out_valid_d;
   t_tile_trans  out_trans_q, out_trans_d;
   t_c2f_arb_src out_src_q,   out_src_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [15:0]  stall_cnt_q, stall_cnt_d;
   logic         stall_err_q, stall_err_d;

   logic load_en;
   logic grant_rsp;
   logic grant_req;

   // The output register may be emptied and refilled in the same cycle.
   assign load_en   = !out_valid_q || fab_ready;
   assign grant_rsp = load_en && rsp_valid &&
                      (!req_valid || (burst_cnt_q < BW'(RSP_BURST_MAX)));
   assign grant_req = load_en && !grant_rsp && req_valid;

   // Upstream FIFOs must never be popped while reset is asserted.
   assign rsp_ready = grant_rsp && !rst;
   assign req_ready = grant_req && !rst;

   always_comb begin
      out_valid_d = out_valid_q;
      out_trans_d = out_trans_q;
      out_src_d   = out_src_q;
      burst_cnt_d = burst_cnt_q;
      stall_cnt_d = '0;
      stall_err_d = stall_err_q;

      if (grant_rsp) begin
         out_valid_d = 1'b1;
         out_trans_d = rsp_trans;
         out_src_d   = ARB_SRC_RSP;
         if (!req_valid) begin
            burst_cnt_d = '0;
         end else if (burst_cnt_q != BW'(RSP_BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
         end
      end else if (grant_req) begin
         out_valid_d = 1'b1;
         out_trans_d = req_trans;
         out_src_d   = ARB_SRC_REQ;
         burst_cnt_d = '0;
      end else if (load_en) begin
         out_valid_d = 1'b0;
      end

      if (out_valid_q && !fab_ready) begin
         stall_cnt_d = (stall_cnt_q == STALL_LIMIT) ? stall_cnt_q : stall_cnt_q + 16'd1;
      end
      if (stall_cnt_d == STALL_LIMIT) begin
         stall_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_trans_q <= '0;
         out_src_q   <= ARB_SRC_REQ;
         burst_cnt_q <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_trans_q <= out_trans_d;
         out_src_q   <= out_src_d;
         burst_cnt_q <= burst_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_trans = out_trans_q;
   assign out_src   = out_src_q;
   assign stall_err = stall_err_q;

endmodule

// File: tb/tb_mini_core_c2f_arb.sv
// Directed bench for mini_core_c2f_arb: table-driven grant/backpressure vectors
// plus hand sequences for the watchdog and asynchronous reset.
module tb_mini_core_c2f_arb;
   import common_pkg::*;
   import mini_core_pkg::*;

   localparam int          BURST = 4;
   localparam logic [15:0] SLIM  = 16'd8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, rsp_valid, fab_ready;
   t_tile_trans  req_trans, rsp_trans;
   logic         req_ready, rsp_ready;
   logic         out_valid;
   t_tile_trans  out_trans;
   t_c2f_arb_src out_src;
   logic         stall_err;

   always #5 clk = ~clk;

   mini_core_c2f_arb #(.RSP_BURST_MAX(BURST), .STALL_LIMIT(SLIM)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_trans(req_trans), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_trans(rsp_trans), .rsp_ready(rsp_ready),
      .fab_ready(fab_ready),
      .out_valid(out_valid), .out_trans(out_trans), .out_src(out_src),
      .stall_err(stall_err)
   );

   int n_chk  = 0;
   int n_fail = 0;
   t_tile_trans exp_trans;

   typedef struct {
      logic         req_v;
      logic         rsp_v;
      logic         fab_r;
      logic         exp_req_rdy;
      logic         exp_rsp_rdy;
      logic         exp_out_v;
      t_c2f_arb_src exp_src;
      int           exp_burst;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rq, input logic rs, input logic fb);
      req_valid = rq;
      rsp_valid = rs;
      fab_ready = fb;
      req_trans = '{dst: 4'h1, op: 4'h3, data: $urandom()};
      rsp_trans = '{dst: 4'h2, op: 4'h5, data: $urandom()};
   endtask

   function automatic void add(input logic rq, input logic rs, input logic fb,
                               input logic erq, input logic ers, input logic eov,
                               input t_c2f_arb_src s, input int eb);
      vecs.push_back('{rq, rs, fb, erq, ers, eov, s, eb});
   endfunction

   // Called at a negedge; each vector spans one clock and ends at the next negedge.
   task automatic run_vecs(input string tag);
      foreach (vecs[i]) begin
         drive(vecs[i].req_v, vecs[i].rsp_v, vecs[i].fab_r);
         #1;
         chk({tag, " req_ready"}, 64'(req_ready), 64'(vecs[i].exp_req_rdy));
         chk({tag, " rsp_ready"}, 64'(rsp_ready), 64'(vecs[i].exp_rsp_rdy));
         if (vecs[i].exp_rsp_rdy) exp_trans = rsp_trans;
         else if (vecs[i].exp_req_rdy) exp_trans = req_trans;
         @(negedge clk);
         chk({tag, " out_valid"}, 64'(out_valid), 64'(vecs[i].exp_out_v));
         chk({tag, " out_src"}, 64'(out_src), 64'(vecs[i].exp_src));
         chk({tag, " out_trans"}, 64'(out_trans), 64'(exp_trans));
         chk({tag, " burst_cnt"}, 64'(dut.burst_cnt_q), 64'(vecs[i].exp_burst));
      end
      vecs.delete();
   endtask

   initial begin
      // Reset: readys held low even with both heads valid.
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      exp_trans = '0;
      #1;
      chk("rst req_ready", 64'(req_ready), 64'd0);
      chk("rst rsp_ready", 64'(rsp_ready), 64'd0);
      repeat (2) @(negedge clk);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_trans", 64'(out_trans), 64'd0);
      chk("rst out_src", 64'(out_src), 64'(ARB_SRC_REQ));
      chk("rst stall_err", 64'(stall_err), 64'd0);
      chk("rst burst_cnt", 64'(dut.burst_cnt_q), 64'd0);
      chk("rst stall_cnt", 64'(dut.stall_cnt_q), 64'd0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // Request stream alone.
      for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 0, 1, ARB_SRC_REQ, 0);
      add(0, 0, 1, 0, 0, 0, ARB_SRC_REQ, 0);
      run_vecs("req_only");

      // Both valid: RSP x4, REQ, repeating.
      for (int i = 0; i < 12; i++) begin
         if (i == 4 || i == 9) add(1, 1, 1, 1, 0, 1, ARB_SRC_REQ, 0);
         else add(1, 1, 1, 0, 1, 1, ARB_SRC_RSP, (i < 4) ? i + 1 : (i < 9) ? i - 4 : i - 9);
      end
      add(0, 0, 1, 0, 0, 0, ARB_SRC_RSP, 2);
      run_vecs("burst");

      // Responses with no request pending never accumulate burst credit.
      for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 1, ARB_SRC_RSP, 0);
      add(1, 0, 1, 1, 0, 1, ARB_SRC_REQ, 0);
      add(0, 0, 1, 0, 0, 0, ARB_SRC_REQ, 0);
      run_vecs("rsp_then_req");

      // Short stall: hold, no pops, then transfer and same-cycle refill.
      add(1, 0, 1, 1, 0, 1, ARB_SRC_REQ, 0);
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 1, ARB_SRC_REQ, 0);
      add(1, 1, 1, 0, 1, 1, ARB_SRC_RSP, 1);
      add(0, 0, 1, 0, 0, 0, ARB_SRC_RSP, 1);
      run_vecs("stall3");

      // Watchdog: sticky after SLIM consecutive stalled cycles.
      drive(1'b1, 1'b0, 1'b1);
      #1;
      exp_trans = req_trans;
      @(negedge clk);
      for (int k = 1; k <= 9; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         #1;
         chk("wd req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
         chk("wd stall_err", 64'(stall_err), 64'(k >= int'(SLIM)));
         chk("wd out_trans", 64'(out_trans), 64'(exp_trans));
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         @(negedge clk);
         chk("wd sticky", 64'(stall_err), 64'd1);
         chk("wd out_valid", 64'(out_valid), 64'd0);
         chk("wd stall_cnt", 64'(dut.stall_cnt_q), 64'd0);
      end

      // Asynchronous reset mid-stall with nonzero burst count.
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 1'b1);
         @(negedge clk);
      end
      chk("ar burst pre", 64'(dut.burst_cnt_q), 64'd2);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 1'b0);
         @(negedge clk);
      end
      chk("ar stall pre", 64'(dut.stall_cnt_q), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar out_valid", 64'(out_valid), 64'd0);
      chk("ar burst_cnt", 64'(dut.burst_cnt_q), 64'd0);
      chk("ar stall_cnt", 64'(dut.stall_cnt_q), 64'd0);
      chk("ar stall_err", 64'(stall_err), 64'd0);
      fab_ready = 1'b1;
      #1;
      chk("ar req_ready", 64'(req_ready), 64'd0);
      chk("ar rsp_ready", 64'(rsp_ready), 64'd0);
      @(negedge clk);
      chk("ar out_valid hold", 64'(out_valid), 64'd0);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      #1;
      chk("ar post rsp_ready", 64'(rsp_ready), 64'd1);
      chk("ar post req_ready", 64'(req_ready), 64'd0);
      exp_trans = rsp_trans;
      @(negedge clk);
      chk("ar post out_valid", 64'(out_valid), 64'd1);
      chk("ar post out_src", 64'(out_src), 64'(ARB_SRC_RSP));
      chk("ar post out_trans", 64'(out_trans), 64'(exp_trans));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
